// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multicycle MIPS control path:
//                opcodes, funct codes, ALU controls, mux selects, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_slt = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // ALU operand B select
    localparam logic [1:0] c_srcb_reg    = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // FSM states; values are visible on state_dbg and must not change
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11,
        ST_TRAP   = 4'd12
    } state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps an R-type funct field to an ALU control code and flags
//                funct values that the datapath does not implement.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    // Funct lookup; unknown codes report invalid and fall back to add
    always_comb begin
        alu_control = c_alu_add;
        funct_valid = 1'b1;
        case (funct)
            c_funct_add: alu_control = c_alu_add;
            c_funct_sub: alu_control = c_alu_sub;
            c_funct_and: alu_control = c_alu_and;
            c_funct_or:  alu_control = c_alu_or;
            c_funct_slt: alu_control = c_alu_slt;
            default:     funct_valid = 1'b0;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Moore control FSM for a multicycle MIPS datapath with a
//                single shared instruction/data memory port and a ready
//                handshake on every memory step.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    state_e     state_q;
    state_e     state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [2:0] w_funct_alu;
    logic       w_funct_valid;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (w_funct_alu),
        .funct_valid (w_funct_valid)
    );

    // State and sticky illegal flag; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore outputs; only FETCH/MEMRD/MEMWR exits and pc_en/ir_write see mem_ready or zero
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = c_srcb_reg;
        alu_control = c_alu_and;
        pc_src      = c_pcsrc_alu;
        pc_en       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = c_srcb_four;
                alu_control = c_alu_add;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target is precomputed into ALUOut here
                alu_src_b   = c_srcb_imm_sh;
                alu_control = c_alu_add;
                case (op)
                    c_op_lw, c_op_sw: state_d = ST_MEMADR;
                    c_op_beq:         state_d = ST_BRANCH;
                    c_op_addi:        state_d = ST_ADDIEX;
                    c_op_j:           state_d = ST_JUMP;
                    c_op_rtype: begin
                        if (w_funct_valid) begin
                            state_d = ST_EXEC;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = ILLEGAL_HALT ? ST_TRAP : ST_FETCH;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? ST_TRAP : ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = c_srcb_imm;
                alu_control = c_alu_add;
                state_d     = (op == c_op_lw) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = w_funct_alu;
                state_d     = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = c_alu_sub;
                pc_src      = c_pcsrc_aluout;
                pc_en       = zero;
                state_d     = ST_FETCH;
            end
            ST_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = c_srcb_imm;
                alu_control = c_alu_add;
                state_d     = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src  = c_pcsrc_jump;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset silences every control so no write leaks out of an aborted step
        if (reset) begin
            state_d     = ST_FETCH;
            illegal_d   = 1'b0;
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            pc_src      = 2'b00;
            pc_en       = 1'b0;
        end
    end

    // Debug view of the state register and the gated sticky flag
    always_comb begin
        state_dbg = STATE_W'(state_q);
        illegal   = illegal_q & ~reset;
    end

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences a multicycle variant of the 32-bit MIPS datapath through fetch, decode, execute, memory and writeback steps. A single memory port is shared between instruction and data, so every memory step holds until a ready handshake completes. Supported instructions are R-type (add, sub, and, or, slt), lw, sw, beq, addi and j. Undecoded opcodes go to a trap, or are skipped as a no-op, depending on a parameter.

Parameters:
ILLEGAL_HALT, 1, 1 = an illegal opcode or funct parks the FSM in TRAP until reset; 0 = treat it as a no-op and return to FETCH.
STATE_W, 4, width of the state register and of state_dbg.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
op  in  6  instr[31:26] taken from the instruction register
funct  in  6  instr[5:0] taken from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access requested
mem_write  out  1  request is a write (valid only with mem_req)
iord  out  1  0 = address from PC; 1 = address from ALUOut register
ir_write  out  1  load the instruction register
reg_dst  out  1  0 = rt is the destination; 1 = rd is the destination
mem_to_reg  out  1  writeback source: 0 = ALUOut; 1 = data register
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC; 1 = register A
alu_src_b  out  2  00 = B; 01 = constant 4; 10 = SignImm; 11 = SignImm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00 = ALU result; 01 = ALUOut; 10 = jump target
pc_en  out  1  PC load enable (includes the branch-taken term)
illegal  out  1  sticky flag: illegal instruction seen
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Reset: state becomes FETCH at the edge where reset=1 is sampled. illegal is cleared. While reset=1, every output except state_dbg is forced to 0.
- A reset asserted mid-instruction aborts it. No partial register or PC write occurs after the reset edge.
- State encoding, fixed for state_dbg:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00.
  - ir_write and pc_en assert only in the cycle mem_ready=1; FETCH then moves to DECODE.
  - Otherwise FETCH holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=add (precomputes the branch target). Next state by op:
  - lw or sw -> MEMADR
  - R-type -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - any other op -> illegal path
- MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Holds until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control decoded from funct (see below), then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero, evaluated in this same cycle.
  - Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- Funct decode for alu_control:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - An unknown funct in an R-type is illegal and is detected in DECODE.
- Illegal path:
  - illegal is set to 1.
  - ILLEGAL_HALT=1: go to TRAP. TRAP holds with all outputs 0 until reset.
  - ILLEGAL_HALT=0: go to FETCH. PC has already advanced by 4.
- Handshake rules:
  - mem_req stays high and iord/mem_write stay stable until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
  - A mem_ready arriving together with reset is ignored; reset wins.
- Control outputs are combinational from state and are glitch-free relative to clk. The exceptions are pc_en, ir_write and the FETCH/MEMRD/MEMWR exits, which are gated by mem_ready or zero.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, each plus one cycle per wait cycle on memory.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams
  - ALU control encodings
  - state encodings
  - alu_src_b and pc_src encodings
- Sub-module alu_decoder (funct -> alu_control, plus a funct_valid output), instantiated in the FSM.

Test Plan:
- reset=1 for 2 cycles, then release with mem_ready=1 -> state_dbg=0, mem_req=1, and ir_write=pc_en=1 on the first post-reset cycle.
- lw (op=100011) with mem_ready low for 3 cycles during MEMRD -> state sequence 0,1,2,3,3,3,3,4,0; reg_write=1 only in MEMWB, with mem_to_reg=1.
- beq with zero=1, then again with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 for the second; both return to FETCH.
- R-type with funct=101010 -> alu_control=111 in EXEC; ALUWB has reg_dst=1.
- op=111111 with ILLEGAL_HALT=1 -> illegal=1 and state=12, held for 10 cycles; reset then clears both.
- sw, with reset asserted in the MEMWR wait cycle -> mem_req=0 while reset=1; state=0 after the edge; mem_write is never asserted together with mem_ready.
